// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants and counter helper for the branch predictor
package bp_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != CNT_ST) begin
            nxt = cnt + 2'd1;
        end else if (!taken && cnt != CNT_SNT) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - datapath-facing signal bundle of the branch predictor
interface branch_predictor_if #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int PERF_W = 32
);
    logic [PC_W-1:0]   pcF;
    logic              stallD;
    logic              flushD;
    logic              pred_takenD;
    logic [IDX_W-1:0]  pred_idxD;
    logic              upd_en;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic              upd_mispred;
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] mispred_cnt;

    modport master (
        output pcF, stallD, flushD, upd_en, upd_idx, upd_taken, upd_mispred,
        input  pred_takenD, pred_idxD, branch_cnt, mispred_cnt
    );

    modport slave (
        input  pcF, stallD, flushD, upd_en, upd_idx, upd_taken, upd_mispred,
        output pred_takenD, pred_idxD, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/bht_table.sv
// rtl/bht_table.sv - 2-bit saturating counter array, async read, sync write
module bht_table
    import bp_pkg::*;
#(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] cnt_d [DEPTH];

    // Read returns the pre-write value, so a same-cycle lookup sees the old counter.
    assign rd_cnt = cnt_q[rd_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = sat_next(cnt_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare direction predictor with D-stage registers and perf counters
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         PC_W     = 32,
    parameter int         IDX_W    = 6,
    parameter int         HIST_W   = 6,
    parameter int         MODE     = 1,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         PERF_W   = 32
) (
    input  logic            clk,
    input  logic            rst,
    branch_predictor_if.slave bp
);

    if (HIST_W > IDX_W || HIST_W < 1) begin : g_bad_hist
        $error("branch_predictor: HIST_W must be in 1..IDX_W");
    end

    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    logic [IDX_W-1:0]  pc_idx;
    logic [IDX_W-1:0]  idx_f;
    logic [1:0]        rd_cnt;
    logic [HIST_W-1:0] ghr_q, ghr_d, ghr_shift;
    logic              pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0]  pred_idx_q, pred_idx_d;
    logic [PERF_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic              unused_pc_bits;

    assign pc_idx         = bp.pcF[IDX_W+1:2];
    assign unused_pc_bits = ^{bp.pcF[PC_W-1:IDX_W+2], bp.pcF[1:0]};

    // History sits in the low index bits; upper bits come straight from the PC.
    assign idx_f = (MODE == MODE_GSHARE) ? (pc_idx ^ IDX_W'(ghr_q)) : pc_idx;

    if (HIST_W == 1) begin : g_hist1
        assign ghr_shift = bp.upd_taken;
    end else begin : g_histn
        assign ghr_shift = {ghr_q[HIST_W-2:0], bp.upd_taken};
    end

    bht_table #(
        .IDX_W   (IDX_W),
        .CNT_INIT(CNT_INIT)
    ) u_bht (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx_f),
        .rd_cnt  (rd_cnt),
        .wr_en   (bp.upd_en),
        .wr_idx  (bp.upd_idx),
        .wr_taken(bp.upd_taken)
    );

    always_comb begin
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        if (bp.flushD) begin
            pred_taken_d = 1'b0;
            pred_idx_d   = '0;
        end else if (!bp.stallD) begin
            pred_taken_d = rd_cnt[1];
            pred_idx_d   = idx_f;
        end
    end

    always_comb begin
        ghr_d         = ghr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bp.upd_en) begin
            ghr_d = ghr_shift;
            if (branch_cnt_q != PERF_MAX) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
            if (bp.upd_mispred && mispred_cnt_q != PERF_MAX) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pred_taken_q  <= 1'b0;
            pred_idx_q    <= '0;
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pred_taken_q  <= pred_taken_d;
            pred_idx_q    <= pred_idx_d;
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bp.pred_takenD = pred_taken_q;
    assign bp.pred_idxD   = pred_idx_q;
    assign bp.branch_cnt  = branch_cnt_q;
    assign bp.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed checks of a bimodal (PERF_W=4) and a gshare predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        stallD, flushD;
    logic        upd_en, upd_taken, upd_mispred;
    logic [5:0]  upd_idx;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.PC_W(32), .IDX_W(6), .PERF_W(4))  bp0 ();
    branch_predictor_if #(.PC_W(32), .IDX_W(6), .PERF_W(32)) bp1 ();

    assign bp0.pcF = pcF;         assign bp1.pcF = pcF;
    assign bp0.stallD = stallD;   assign bp1.stallD = stallD;
    assign bp0.flushD = flushD;   assign bp1.flushD = flushD;
    assign bp0.upd_en = upd_en;   assign bp1.upd_en = upd_en;
    assign bp0.upd_idx = upd_idx; assign bp1.upd_idx = upd_idx;
    assign bp0.upd_taken = upd_taken;     assign bp1.upd_taken = upd_taken;
    assign bp0.upd_mispred = upd_mispred; assign bp1.upd_mispred = upd_mispred;

    branch_predictor #(.PC_W(32), .IDX_W(6), .HIST_W(6), .MODE(0), .CNT_INIT(2'b01), .PERF_W(4))
        dut0 (.clk(clk), .rst(rst), .bp(bp0));
    branch_predictor #(.PC_W(32), .IDX_W(6), .HIST_W(6), .MODE(1), .CNT_INIT(2'b01), .PERF_W(32))
        dut1 (.clk(clk), .rst(rst), .bp(bp1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic upd(input logic [5:0] idx, input logic taken, input logic mis);
        upd_en = 1'b1; upd_idx = idx; upd_taken = taken; upd_mispred = mis;
    endtask

    task automatic no_upd();
        upd_en = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pcF = 32'h0; stallD = 1'b0; flushD = 1'b0;
        no_upd();

        // Reset
        tick(); tick();
        rst = 1'b1; pcF = 32'h0040_0000;
        tick();
        check("rst_taken0", {31'd0, bp0.pred_takenD}, 32'd0);
        check("rst_idx0",   {26'd0, bp0.pred_idxD}, 32'd0);
        check("rst_idx1",   {26'd0, bp1.pred_idxD}, 32'd0);
        check("rst_bcnt0",  {28'd0, bp0.branch_cnt}, 32'd0);
        check("rst_mcnt0",  {28'd0, bp0.mispred_cnt}, 32'd0);
        check("rst_bcnt1",  bp1.branch_cnt, 32'd0);
        check("rst_mcnt1",  bp1.mispred_cnt, 32'd0);

        // Saturation on idx 0x04 (bimodal)
        pcF = 32'h0040_0010;
        upd(6'h04, 1'b1, 1'b0);
        tick();
        check("collide_old_cnt", {31'd0, bp0.pred_takenD}, 32'd0);
        tick(); tick();
        no_upd();
        tick();
        check("sat_st_taken", {31'd0, bp0.pred_takenD}, 32'd1);
        check("sat_st_idx",   {26'd0, bp0.pred_idxD}, 32'h04);
        upd(6'h04, 1'b0, 1'b1);
        tick();
        no_upd();
        tick();
        check("sat_wt_taken", {31'd0, bp0.pred_takenD}, 32'd1);
        upd(6'h04, 1'b0, 1'b1);
        tick(); tick();
        no_upd();
        tick();
        check("sat_snt_taken", {31'd0, bp0.pred_takenD}, 32'd0);
        check("bcnt0_6", {28'd0, bp0.branch_cnt}, 32'd6);
        check("mcnt0_3", {28'd0, bp0.mispred_cnt}, 32'd3);
        upd(6'h04, 1'b0, 1'b0);
        tick(); tick();
        no_upd();
        tick();
        check("sat_snt_floor", {31'd0, bp0.pred_takenD}, 32'd0);

        // gshare history after outcomes 1,0,1 is 000101
        rst = 1'b0;
        tick();
        rst = 1'b1;
        upd(6'h3F, 1'b1, 1'b0); tick();
        upd(6'h3F, 1'b0, 1'b0); tick();
        upd(6'h3F, 1'b1, 1'b0); tick();
        no_upd();
        pcF = 32'h0040_0010;
        tick();
        check("gs_idx1",   {26'd0, bp1.pred_idxD}, 32'h01);
        check("gs_taken1", {31'd0, bp1.pred_takenD}, 32'd0);
        check("bm_idx0",   {26'd0, bp0.pred_idxD}, 32'h04);
        pcF = 32'h0040_00E8;
        tick();
        check("gs_idx_3f",   {26'd0, bp1.pred_idxD}, 32'h3F);
        check("gs_taken_3f", {31'd0, bp1.pred_takenD}, 32'd1);
        check("bm_idx_3a",   {26'd0, bp0.pred_idxD}, 32'h3A);

        // Stall / flush
        pcF = 32'h0040_0010;
        tick();
        stallD = 1'b1; pcF = 32'h0040_0020;
        tick();
        check("stall_hold_idx", {26'd0, bp0.pred_idxD}, 32'h04);
        flushD = 1'b1;
        tick();
        check("flush_idx",   {26'd0, bp0.pred_idxD}, 32'h00);
        check("flush_taken", {31'd0, bp1.pred_takenD}, 32'd0);
        check("flush_idx1",  {26'd0, bp1.pred_idxD}, 32'h00);
        flushD = 1'b0; stallD = 1'b0;
        tick();
        check("unstall_idx", {26'd0, bp0.pred_idxD}, 32'h08);

        // Same-cycle lookup and update to idx 0x04
        rst = 1'b0;
        tick();
        rst = 1'b1; pcF = 32'h0040_0010;
        upd(6'h04, 1'b1, 1'b1);
        tick();
        check("coll_taken0",  {31'd0, bp0.pred_takenD}, 32'd0);
        check("coll_gs_idx",  {26'd0, bp1.pred_idxD}, 32'h04);
        no_upd();
        tick();
        check("coll_next_taken", {31'd0, bp0.pred_takenD}, 32'd1);
        check("coll_gs_next_idx", {26'd0, bp1.pred_idxD}, 32'h05);
        check("coll_gs_next_tk",  {31'd0, bp1.pred_takenD}, 32'd0);

        // Perf counter saturation (PERF_W=4 on dut0)
        for (int i = 0; i < 20; i++) begin
            upd(6'h10, i[0], 1'b1);
            tick();
        end
        no_upd();
        tick();
        check("perf_bsat", {28'd0, bp0.branch_cnt}, 32'hF);
        check("perf_msat", {28'd0, bp0.mispred_cnt}, 32'hF);
        check("perf_b32",  bp1.branch_cnt, 32'd21);
        check("perf_m32",  bp1.mispred_cnt, 32'd21);
        upd(6'h10, 1'b1, 1'b1);
        tick();
        check("perf_bstay", {28'd0, bp0.branch_cnt}, 32'hF);
        check("perf_mstay", {28'd0, bp0.mispred_cnt}, 32'hF);
        rst = 1'b0;
        tick();
        check("perf_rst_b", {28'd0, bp0.branch_cnt}, 32'd0);
        check("perf_rst_m", {28'd0, bp0.mispred_cnt}, 32'd0);
        tick();
        check("rst_ignores_upd", bp1.branch_cnt, 32'd0);
        no_upd();
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
